// File: rtl/a25_wb_bridge_pkg.sv
// Shared types and helpers for the a25 memory-stage to Wishbone bridge.
// Lanes are the four 32-bit words of a 128-bit line.
package a25_wb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef logic [1:0] lane_t;

    localparam logic [3:0] WB_SEL_ALL = 4'hF;

    // One bit per lane: set when any byte of that lane is enabled.
    function automatic logic [3:0] beat_mask(input logic [15:0] byte_enable);
        logic [3:0] mask;
        for (int l = 0; l < 4; l++) begin
            mask[l] = |byte_enable[4*l +: 4];
        end
        return mask;
    endfunction

    // Lowest set lane of a mask; lane 0 when the mask is empty.
    function automatic lane_t first_lane(input logic [3:0] mask);
        lane_t lane;
        lane = 2'd0;
        for (int l = 3; l >= 0; l--) begin
            lane = mask[l] ? lane_t'(l) : lane;
        end
        return lane;
    endfunction

endpackage

// File: rtl/a25_wb_beat_timer.sv
// Per-beat ack watchdog: counts cycles a beat has been outstanding and
// flags expiry on the TIMEOUT-th cycle. TIMEOUT = 0 never expires.
module a25_wb_beat_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};

    logic [CW-1:0] cnt_r;

    // Cycle counter for the beat currently on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (en && (cnt_r != LIMIT)) begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && en && (cnt_r == LIMIT);

endmodule

// File: rtl/a25_wb_bridge.sv
// Runs a25 128-bit cached/uncached requests as 32-bit Wishbone classic beats,
// skipping unenabled write lanes and timing out silent slaves.
module a25_wb_bridge
    import a25_wb_bridge_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_cached_req,
    input  logic         i_uncached_req,
    input  logic         i_write,
    input  logic [15:0]  i_byte_enable,
    input  logic [127:0] i_write_data,
    input  logic [31:0]  i_address,
    output logic         o_cached_ready,
    output logic         o_uncached_ready,
    output logic [127:0] o_cached_rdata,
    output logic [127:0] o_uncached_rdata,
    output logic [31:0]  o_wb_adr,
    output logic [3:0]   o_wb_sel,
    output logic         o_wb_we,
    output logic [31:0]  o_wb_dat,
    output logic         o_wb_cyc,
    output logic         o_wb_stb,
    input  logic [31:0]  i_wb_dat,
    input  logic         i_wb_ack,
    input  logic         i_wb_err,
    output logic         o_bus_error
);

    state_e        state_r, state_nxt;
    logic [3:0]    mask_r, mask_nxt;
    logic          we_r, we_nxt;
    logic          cached_r, cached_nxt;
    logic [27:0]   adr_hi_r, adr_hi_nxt;
    logic [15:0]   be_r, be_nxt;
    logic [127:0]  wdata_r, wdata_nxt;
    logic [127:0]  line_r, line_nxt;
    logic [127:0]  c_rdata_r, c_rdata_nxt;
    logic [127:0]  u_rdata_r, u_rdata_nxt;
    logic [31:0]   wb_adr_r, wb_adr_nxt;
    logic [31:0]   wb_dat_r, wb_dat_nxt;
    logic [3:0]    wb_sel_r, wb_sel_nxt;
    logic          wb_we_r, wb_we_nxt;
    logic          wb_cyc_r, wb_cyc_nxt;
    logic          c_ready_r, c_ready_nxt;
    logic          u_ready_r, u_ready_nxt;
    logic          bus_error_r, bus_error_nxt;
    logic [3:0]    req_mask_s, rest_mask_s;
    lane_t         lane_s, req_lane_s, next_lane_s;
    logic          beat_end_s, expired_s, timer_clr_s, timer_en_s;
    logic [127:0]  line_upd_s;
    logic          unused_s;

    assign unused_s = ^i_address[1:0];

    // Reads: all lanes (cached) or the addressed lane; writes: enabled lanes only.
    assign req_mask_s  = i_write ? beat_mask(i_byte_enable)
                                 : (i_cached_req ? 4'b1111 : (4'b0001 << i_address[3:2]));
    assign req_lane_s  = first_lane(req_mask_s);
    assign lane_s      = first_lane(mask_r);
    assign rest_mask_s = mask_r & ~(4'b0001 << lane_s);
    assign next_lane_s = first_lane(rest_mask_s);

    assign timer_en_s  = (state_r == ST_BUS) && wb_cyc_r;
    assign beat_end_s  = timer_en_s && (i_wb_ack || i_wb_err || expired_s);
    assign timer_clr_s = (state_r != ST_BUS) || beat_end_s;

    a25_wb_beat_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (reset),
        .clr     (timer_clr_s),
        .en      (timer_en_s),
        .expired (expired_s)
    );

    // Line image with the terminating beat's lane merged in (0 on err/timeout).
    always_comb begin
        line_upd_s = line_r;
        line_upd_s[{lane_s, 5'b00000} +: 32] = (i_wb_ack && !i_wb_err) ? i_wb_dat : 32'h0;
    end

    // Next-state and next-output logic for the request FSM.
    always_comb begin
        state_nxt     = state_r;
        mask_nxt      = mask_r;
        we_nxt        = we_r;
        cached_nxt    = cached_r;
        adr_hi_nxt    = adr_hi_r;
        be_nxt        = be_r;
        wdata_nxt     = wdata_r;
        line_nxt      = line_r;
        c_rdata_nxt   = c_rdata_r;
        u_rdata_nxt   = u_rdata_r;
        wb_adr_nxt    = wb_adr_r;
        wb_dat_nxt    = wb_dat_r;
        wb_sel_nxt    = wb_sel_r;
        wb_we_nxt     = wb_we_r;
        wb_cyc_nxt    = wb_cyc_r;
        c_ready_nxt   = 1'b0;
        u_ready_nxt   = 1'b0;
        bus_error_nxt = bus_error_r;
        case (state_r)
            ST_IDLE: begin
                if (i_cached_req || i_uncached_req) begin
                    cached_nxt = i_cached_req;
                    we_nxt     = i_write;
                    adr_hi_nxt = i_address[31:4];
                    be_nxt     = i_byte_enable;
                    wdata_nxt  = i_write_data;
                    line_nxt   = 128'h0;
                    mask_nxt   = req_mask_s;
                    if (req_mask_s == 4'b0000) begin
                        state_nxt   = ST_DONE;
                        c_ready_nxt = i_cached_req;
                        u_ready_nxt = !i_cached_req;
                    end else begin
                        state_nxt  = ST_BUS;
                        wb_cyc_nxt = 1'b1;
                        wb_we_nxt  = i_write;
                        wb_adr_nxt = {i_address[31:4], req_lane_s, 2'b00};
                        wb_sel_nxt = i_write ? i_byte_enable[{req_lane_s, 2'b00} +: 4] : WB_SEL_ALL;
                        wb_dat_nxt = i_write_data[{req_lane_s, 5'b00000} +: 32];
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (beat_end_s) begin
                    line_nxt = line_upd_s;
                    mask_nxt = rest_mask_s;
                    if (i_wb_err || !i_wb_ack) begin
                        bus_error_nxt = 1'b1;
                    end else begin
                        bus_error_nxt = bus_error_r;
                    end
                    if (rest_mask_s == 4'b0000) begin
                        state_nxt   = ST_DONE;
                        wb_cyc_nxt  = 1'b0;
                        wb_we_nxt   = 1'b0;
                        c_ready_nxt = cached_r;
                        u_ready_nxt = !cached_r;
                        if (we_r) begin
                            c_rdata_nxt = c_rdata_r;
                        end else if (cached_r) begin
                            c_rdata_nxt = line_upd_s;
                        end else begin
                            u_rdata_nxt = line_upd_s;
                        end
                    end else begin
                        wb_adr_nxt = {adr_hi_r, next_lane_s, 2'b00};
                        wb_sel_nxt = we_r ? be_r[{next_lane_s, 2'b00} +: 4] : WB_SEL_ALL;
                        wb_dat_nxt = wdata_r[{next_lane_s, 5'b00000} +: 32];
                    end
                end else begin
                    state_nxt = ST_BUS;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops cyc/stb immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            mask_r      <= 4'h0;
            we_r        <= 1'b0;
            cached_r    <= 1'b0;
            adr_hi_r    <= 28'h0;
            be_r        <= 16'h0;
            wdata_r     <= 128'h0;
            line_r      <= 128'h0;
            c_rdata_r   <= 128'h0;
            u_rdata_r   <= 128'h0;
            wb_adr_r    <= 32'h0;
            wb_dat_r    <= 32'h0;
            wb_sel_r    <= 4'h0;
            wb_we_r     <= 1'b0;
            wb_cyc_r    <= 1'b0;
            c_ready_r   <= 1'b0;
            u_ready_r   <= 1'b0;
            bus_error_r <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            mask_r      <= mask_nxt;
            we_r        <= we_nxt;
            cached_r    <= cached_nxt;
            adr_hi_r    <= adr_hi_nxt;
            be_r        <= be_nxt;
            wdata_r     <= wdata_nxt;
            line_r      <= line_nxt;
            c_rdata_r   <= c_rdata_nxt;
            u_rdata_r   <= u_rdata_nxt;
            wb_adr_r    <= wb_adr_nxt;
            wb_dat_r    <= wb_dat_nxt;
            wb_sel_r    <= wb_sel_nxt;
            wb_we_r     <= wb_we_nxt;
            wb_cyc_r    <= wb_cyc_nxt;
            c_ready_r   <= c_ready_nxt;
            u_ready_r   <= u_ready_nxt;
            bus_error_r <= bus_error_nxt;
        end
    end

    assign o_cached_ready   = c_ready_r;
    assign o_uncached_ready = u_ready_r;
    assign o_cached_rdata   = c_rdata_r;
    assign o_uncached_rdata = u_rdata_r;
    assign o_wb_adr         = wb_adr_r;
    assign o_wb_sel         = wb_sel_r;
    assign o_wb_we          = wb_we_r;
    assign o_wb_dat         = wb_dat_r;
    assign o_wb_cyc         = wb_cyc_r;
    assign o_wb_stb         = wb_cyc_r;
    assign o_bus_error      = bus_error_r;

endmodule

// File: tb/tb_a25_wb_bridge.sv
// Self-checking bench for a25_wb_bridge: directed and randomized requests
// against a behavioural Wishbone slave and a line-level reference model.
module tb_a25_wb_bridge;

    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_cached_req, i_uncached_req, i_write;
    logic [15:0]  i_byte_enable;
    logic [127:0] i_write_data;
    logic [31:0]  i_address;
    logic         o_cached_ready, o_uncached_ready;
    logic [127:0] o_cached_rdata, o_uncached_rdata;
    logic [31:0]  o_wb_adr, o_wb_dat;
    logic [3:0]   o_wb_sel;
    logic         o_wb_we, o_wb_cyc, o_wb_stb;
    logic [31:0]  i_wb_dat;
    logic         i_wb_ack, i_wb_err;
    logic         o_bus_error;

    always #5 clk = ~clk;

    a25_wb_bridge #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .i_cached_req(i_cached_req), .i_uncached_req(i_uncached_req),
        .i_write(i_write), .i_byte_enable(i_byte_enable),
        .i_write_data(i_write_data), .i_address(i_address),
        .o_cached_ready(o_cached_ready), .o_uncached_ready(o_uncached_ready),
        .o_cached_rdata(o_cached_rdata), .o_uncached_rdata(o_uncached_rdata),
        .o_wb_adr(o_wb_adr), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
        .o_wb_dat(o_wb_dat), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
        .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
        .o_bus_error(o_bus_error)
    );

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] dat;
        logic        err;
    } beat_t;

    beat_t       log_q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          slave_mode = 0;   // 0 ack at once, 1 never respond, 2 random wait/err/ack
    int          log_base = 0;
    logic [31:0] rd_tab [4];
    int          stb_total = 0;
    int          cpulse = 0;
    int          upulse = 0;
    int          waits = 0;

    logic         exp_err = 1'b0;
    logic [127:0] exp_c = 128'h0;
    logic [127:0] exp_u = 128'h0;
    int           exp_cp = 0;
    int           exp_up = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural slave: answers beats on the falling edge, logs each terminated beat.
    always @(negedge clk) begin : slave
        logic do_ack, do_err;
        int   r, idx;
        beat_t b;
        do_ack = 1'b0;
        do_err = 1'b0;
        if (o_cached_ready) cpulse++;
        if (o_uncached_ready) upulse++;
        if (o_wb_cyc && o_wb_stb) begin
            stb_total++;
            if (slave_mode == 0) begin
                do_ack = 1'b1;
            end else if (slave_mode == 2) begin
                r = $urandom_range(0, 3);
                if (r == 0 && waits < 3) waits++;
                else if (r == 1) do_err = 1'b1;
                else do_ack = 1'b1;
            end
        end
        idx = (log_q.size() - log_base) & 3;
        i_wb_ack = do_ack;
        i_wb_err = do_err;
        i_wb_dat = do_ack ? rd_tab[idx] : $urandom;
        if (do_ack || do_err) begin
            waits = 0;
            b.adr = o_wb_adr; b.sel = o_wb_sel; b.we = o_wb_we; b.dat = o_wb_dat; b.err = do_err;
            log_q.push_back(b);
        end else if (!o_wb_cyc && slave_mode == 2 && $urandom_range(0, 7) == 0) begin
            i_wb_err = 1'b1;
        end
    end

    task automatic do_req(input logic cached, input logic wr, input logic [15:0] be,
                          input logic [127:0] wd, input logic [31:0] addr, input int mode,
                          input string tag);
        int lanes[$];
        int n, lat, sb0;
        logic got;
        logic [127:0] line;
        logic [3:0] esel;
        beat_t b;
        for (int l = 0; l < 4; l++) begin
            if (wr) begin
                if (be[4*l +: 4] != 4'h0) lanes.push_back(l);
            end else if (cached || int'(addr[3:2]) == l) begin
                lanes.push_back(l);
            end
        end
        @(posedge clk); #1;
        slave_mode = mode;
        log_base = log_q.size();
        sb0 = stb_total;
        i_cached_req = cached; i_uncached_req = !cached;
        i_write = wr; i_byte_enable = be; i_write_data = wd; i_address = addr;
        lat = 0;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            lat++;
            got = cached ? o_cached_ready : o_uncached_ready;
        end
        check({tag, ":ready_seen"}, got, 1'b1);
        check({tag, ":cyc_low_at_ready"}, o_wb_cyc, 1'b0);
        i_cached_req = 1'b0; i_uncached_req = 1'b0;
        if (mode == 0) check({tag, ":latency"}, lat, lanes.size() + 2);
        @(negedge clk); #1;
        check({tag, ":ready_one_cycle"}, {o_cached_ready, o_uncached_ready}, 2'b00);
        if (mode == 0) check({tag, ":stb_cycles"}, stb_total - sb0, lanes.size());
        if (mode == 1) check({tag, ":timeout_stb_cycles"}, stb_total - sb0, TO * lanes.size());
        n = log_q.size() - log_base;
        if (mode != 1) begin
            check({tag, ":beat_count"}, n, lanes.size());
            for (int i = 0; i < lanes.size(); i++) begin
                if (i < n) begin
                    b = log_q[log_base + i];
                    esel = wr ? be[4*lanes[i] +: 4] : 4'hF;
                    check($sformatf("%s:adr%0d", tag, i), b.adr, {addr[31:4], 4'h0} + 32'(4 * lanes[i]));
                    check($sformatf("%s:sel%0d", tag, i), b.sel, esel);
                    check($sformatf("%s:we%0d", tag, i), b.we, wr);
                    if (wr) check($sformatf("%s:dat%0d", tag, i), b.dat, wd[32*lanes[i] +: 32]);
                    if (b.err) exp_err = 1'b1;
                end
            end
        end else if (lanes.size() > 0) begin
            exp_err = 1'b1;
        end
        if (!wr) begin
            line = 128'h0;
            for (int i = 0; i < lanes.size(); i++) begin
                if (mode != 1 && i < n && !log_q[log_base + i].err) line[32*lanes[i] +: 32] = rd_tab[i];
            end
            if (cached) exp_c = line;
            else exp_u = line;
        end
        if (cached) exp_cp++;
        else exp_up++;
        check({tag, ":bus_error"}, o_bus_error, exp_err);
        check({tag, ":cached_rdata"}, o_cached_rdata, exp_c);
        check({tag, ":uncached_rdata"}, o_uncached_rdata, exp_u);
        repeat (2) @(posedge clk);
        #1;
        check({tag, ":cached_pulses"}, cpulse, exp_cp);
        check({tag, ":uncached_pulses"}, upulse, exp_up);
    endtask

    initial begin
        logic got;
        reset = 1'b0;
        i_cached_req = 1'b0; i_uncached_req = 1'b0; i_write = 1'b0;
        i_byte_enable = 16'h0; i_write_data = 128'h0; i_address = 32'h0;
        for (int i = 0; i < 4; i++) rd_tab[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset:bus", {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_adr, o_wb_dat}, 128'h0);
        check("reset:ready_err", {o_cached_ready, o_uncached_ready, o_bus_error}, 128'h0);
        check("reset:cached_rdata", o_cached_rdata, 128'h0);
        check("reset:uncached_rdata", o_uncached_rdata, 128'h0);
        reset = 1'b1;

        rd_tab[0] = 32'hA0; rd_tab[1] = 32'hA1; rd_tab[2] = 32'hA2; rd_tab[3] = 32'hA3;
        do_req(1'b1, 1'b0, 16'h0, 128'h0, 32'h1000_0024, 0, "cached_rd");
        check("cached_rd:line", o_cached_rdata, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

        rd_tab[0] = 32'h1234_5678;
        do_req(1'b0, 1'b0, 16'h0, 128'h0, 32'h0000_0108, 0, "uncached_rd");
        check("uncached_rd:line", o_uncached_rdata, 128'h1234_5678 << 64);

        do_req(1'b0, 1'b1, 16'h3001, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
               32'h0000_0200, 0, "sparse_wr");
        do_req(1'b1, 1'b1, 16'h0000, 128'hFFFF, 32'h0000_0300, 0, "empty_wr");

        for (int k = 0; k < 24; k++) begin
            logic [15:0] be;
            logic [127:0] wd;
            be = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            wd = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < 4; i++) rd_tab[i] = $urandom;
            do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), be, wd, $urandom,
                   2 * $urandom_range(0, 1), $sformatf("rand%0d", k));
        end

        do_req(1'b0, 1'b0, 16'h0, 128'h0, 32'h0000_0304, 1, "timeout_rd");

        // Both requests high, reset asserted during beat 2 of the cached read.
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) rd_tab[i] = $urandom;
        slave_mode = 0;
        log_base = log_q.size();
        i_cached_req = 1'b1; i_uncached_req = 1'b1; i_write = 1'b0; i_address = 32'h2000_0048;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk); #1;
            got = (log_q.size() > log_base);
        end
        check("abort:first_beat_seen", got, 1'b1);
        if (got) check("abort:cached_first", log_q[log_base].adr, 32'h2000_0040);
        slave_mode = 1;
        @(posedge clk); #2;
        check("abort:beat2_on_bus", {o_wb_cyc, o_wb_stb, o_wb_adr}, {2'b11, 32'h2000_0044});
        reset = 1'b0;
        #1;
        check("abort:cyc_stb_drop", {o_wb_cyc, o_wb_stb}, 2'b00);
        check("abort:outputs_zero", {o_wb_we, o_wb_sel, o_wb_adr, o_wb_dat, o_cached_ready,
                                     o_uncached_ready, o_bus_error}, 128'h0);
        check("abort:rdata_zero", o_cached_rdata | o_uncached_rdata, 128'h0);
        exp_err = 1'b0; exp_c = 128'h0; exp_u = 128'h0;
        i_cached_req = 1'b0; i_uncached_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        slave_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        check("abort:no_cached_pulse", cpulse, exp_cp);
        check("abort:no_uncached_pulse", upulse, exp_up);

        rd_tab[0] = 32'hCAFE_F00D;
        do_req(1'b0, 1'b0, 16'h0, 128'h0, 32'h0000_0400, 0, "post_reset_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
